// File: rtl/tea_round_engine.sv
// ---------------------------------------------------------------------------
// tea_round_engine
//   Iterative TEA block cipher core. One clock performs one full TEA cycle,
//   i.e. two Feistel half-rounds, using two chained tea_function_f instances.
//   The core encrypts or decrypts one 64-bit block with a 128-bit key and
//   uses a valid/ready handshake on both its input and its output.
//
// Ports
//   clk        in   1    system clock, rising edge
//   rst        in   1    asynchronous, active-high reset
//   in_valid   in   1    din / key / decrypt are valid
//   in_ready   out  1    engine can accept a block (IDLE)
//   decrypt    in   1    0 = encrypt, 1 = decrypt, sampled on accept
//   key        in   128  {k0,k1,k2,k3}, sampled on accept
//   din        in   64   {v0,v1}, sampled on accept
//   out_valid  out  1    dout holds a finished block (DONE)
//   out_ready  in   1    downstream accepts dout
//   dout       out  64   result {v0,v1}; zero outside DONE
//   busy       out  1    high in RUN or DONE
// ---------------------------------------------------------------------------

// TEA round function: F(a,b,s,x) = ((x<<4)+a) ^ (x+s) ^ ((x>>5)+b), mod 2^32.
module tea_function_f (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] s,
  input  logic [31:0] x,
  output logic [31:0] out32
);
  assign out32 = ((x << 4) + a) ^ (x + s) ^ ((x >> 5) + b);
endmodule

module tea_round_engine #(
  parameter int          ROUNDS = 32,
  parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         decrypt,
  input  logic [127:0] key,
  input  logic [63:0]  din,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  dout,
  output logic         busy
);

  // Decrypt starts from the sum the encrypt schedule would end on.
  localparam logic [63:0] SUM_DEC_FULL = 64'(DELTA) * 64'(ROUNDS);
  localparam logic [31:0] SUM_DEC      = SUM_DEC_FULL[31:0];
  localparam logic [6:0]  CNT_LAST     = 7'(ROUNDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [6:0]    cnt_q, cnt_d;
  logic [31:0]   sum_q, sum_d;
  logic [31:0]   v0_q, v0_d;
  logic [31:0]   v1_q, v1_d;
  logic [127:0]  key_q, key_d;
  logic          dec_q, dec_d;

  logic [31:0]   k0, k1, k2, k3;
  logic [31:0]   f1_a, f1_b, f1_x, f1_out;
  logic [31:0]   f2_a, f2_b, f2_out;
  logic [31:0]   half1, half2;

  assign k0 = key_q[127:96];
  assign k1 = key_q[95:64];
  assign k2 = key_q[63:32];
  assign k3 = key_q[31:0];

  // Encrypt updates v0 first (from v1); decrypt undoes that in reverse order,
  // updating v1 first (from v0). The second half-round always consumes the
  // word produced by the first.
  assign f1_a  = dec_q ? k2 : k0;
  assign f1_b  = dec_q ? k3 : k1;
  assign f1_x  = dec_q ? v0_q : v1_q;
  assign half1 = dec_q ? (v1_q - f1_out) : (v0_q + f1_out);

  assign f2_a  = dec_q ? k0 : k2;
  assign f2_b  = dec_q ? k1 : k3;
  assign half2 = dec_q ? (v0_q - f2_out) : (v1_q + f2_out);

  tea_function_f u_f1 (
    .a     (f1_a),
    .b     (f1_b),
    .s     (sum_q),
    .x     (f1_x),
    .out32 (f1_out)
  );

  tea_function_f u_f2 (
    .a     (f2_a),
    .b     (f2_b),
    .s     (sum_q),
    .x     (half1),
    .out32 (f2_out)
  );

  // State register and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sum_q   <= '0;
      v0_q    <= '0;
      v1_q    <= '0;
      key_q   <= '0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      v0_q    <= v0_d;
      v1_q    <= v1_d;
      key_q   <= key_d;
      dec_q   <= dec_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)           state_d = RUN;
      RUN:     if (cnt_q == CNT_LAST)  state_d = DONE;
      DONE:    if (out_ready)          state_d = IDLE;
      default:                         state_d = IDLE;
    endcase
  end

  // Datapath next values: latch on accept, one TEA cycle per RUN clock.
  always_comb begin
    cnt_d = cnt_q;
    sum_d = sum_q;
    v0_d  = v0_q;
    v1_d  = v1_q;
    key_d = key_q;
    dec_d = dec_q;
    if (state_q == IDLE && in_valid) begin
      key_d = key;
      dec_d = decrypt;
      v0_d  = din[63:32];
      v1_d  = din[31:0];
      cnt_d = '0;
      sum_d = decrypt ? SUM_DEC : DELTA;
    end else if (state_q == RUN) begin
      v0_d  = dec_q ? half2 : half1;
      v1_d  = dec_q ? half1 : half2;
      sum_d = dec_q ? (sum_q - DELTA) : (sum_q + DELTA);
      cnt_d = cnt_q + 7'd1;
    end
  end

  // Outputs decoded from the state register, so reset clears them at once.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    dout      = (state_q == DONE) ? {v0_q, v1_q} : 64'd0;
  end

endmodule

// File: tb/tb_tea_round_engine.sv
// ---------------------------------------------------------------------------
// tb_tea_round_engine
//   Self-checking bench for tea_round_engine: a vector table, randomized
//   blocks compared against a C-style TEA reference, and hand-written
//   sequences for backpressure, ignored input, and reset in RUN/DONE.
// ---------------------------------------------------------------------------
module tb_tea_round_engine;

  localparam int          ROUNDS = 32;
  localparam logic [31:0] DELTA  = 32'h9E3779B9;

  localparam logic [127:0] K3   = 128'h0123456789ABCDEF_FEDCBA9876543210;
  localparam logic [63:0]  D3   = 64'hDEADBEEF_CAFEBABE;
  localparam logic [63:0]  ZENC = 64'h41EA3A0A_94BAA940;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         decrypt;
  logic [127:0] key;
  logic [63:0]  din;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  dout;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  tea_round_engine #(
    .ROUNDS (ROUNDS),
    .DELTA  (DELTA)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .decrypt   (decrypt),
    .key       (key),
    .din       (din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference TEA, written the way the C reference is: sum built by repeated
  // addition of DELTA, then the classic encrypt/decrypt loops.
  function automatic logic [63:0] tea_model(input logic dec, input logic [127:0] k,
                                            input logic [63:0] d, input int rounds);
    logic [31:0] v0, v1, s, k0, k1, k2, k3;
    v0 = d[63:32];
    v1 = d[31:0];
    k0 = k[127:96];
    k1 = k[95:64];
    k2 = k[63:32];
    k3 = k[31:0];
    s  = 32'd0;
    if (!dec) begin
      for (int i = 0; i < rounds; i++) begin
        s  = s + DELTA;
        v0 = v0 + (((v1 << 4) + k0) ^ (v1 + s) ^ ((v1 >> 5) + k1));
        v1 = v1 + (((v0 << 4) + k2) ^ (v0 + s) ^ ((v0 >> 5) + k3));
      end
    end else begin
      for (int i = 0; i < rounds; i++) s = s + DELTA;
      for (int i = 0; i < rounds; i++) begin
        v1 = v1 - (((v0 << 4) + k2) ^ (v0 + s) ^ ((v0 >> 5) + k3));
        v0 = v0 - (((v1 << 4) + k0) ^ (v1 + s) ^ ((v1 >> 5) + k1));
        s  = s - DELTA;
      end
    end
    return {v0, v1};
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", nm, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge just after the accept edge,
  // with the inputs scrambled so late changes would corrupt a sloppy design.
  task automatic send(input logic d, input logic [127:0] k, input logic [63:0] x);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("send_in_ready", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1;
    decrypt  = d;
    key      = k;
    din      = x;
    @(negedge clk);
    in_valid = 1'b0;
    decrypt  = ~d;
    key      = {$urandom, $urandom, $urandom, $urandom};
    din      = {$urandom, $urandom};
  endtask

  task automatic wait_out(output logic [63:0] r, output int lat);
    lat = 0;
    while (!out_valid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    chk("out_valid_seen", {63'd0, out_valid}, 64'd1);
    r = dout;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("idle_after_release", {61'd0, in_ready, out_valid, busy}, 64'd4);
  endtask

  typedef struct {
    logic         dec;
    logic [127:0] key;
    logic [63:0]  din;
    logic [63:0]  exp;
  } vec_t;

  vec_t vt[3];

  initial begin
    logic [63:0] r, r2;
    int          lat;
    logic        rd;
    logic [127:0] rk;
    logic [63:0]  rx;

    vt[0] = '{dec: 1'b0, key: 128'd0, din: 64'd0, exp: ZENC};
    vt[1] = '{dec: 1'b1, key: 128'd0, din: ZENC,  exp: 64'd0};
    vt[2] = '{dec: 1'b0, key: K3,     din: D3,    exp: tea_model(1'b0, K3, D3, ROUNDS)};

    rst = 1'b1; in_valid = 1'b0; decrypt = 1'b0; key = '0; din = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_flags", {61'd0, in_ready, out_valid, busy}, 64'd4);
    chk("reset_dout", dout, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Vector table: value and exact latency (out_valid ROUNDS edges after accept).
    for (int i = 0; i < 3; i++) begin
      send(vt[i].dec, vt[i].key, vt[i].din);
      chk($sformatf("busy_run_%0d", i), {61'd0, in_ready, out_valid, busy}, 64'd1);
      wait_out(r, lat);
      chk($sformatf("vec_dout_%0d", i), r, vt[i].exp);
      chk($sformatf("vec_latency_%0d", i), 64'(lat), 64'(ROUNDS));
      release_out();
    end

    // Round trip through the DUT with a non-trivial key.
    send(1'b0, K3, D3);
    wait_out(r, lat);
    release_out();
    send(1'b1, K3, r);
    wait_out(r2, lat);
    chk("roundtrip", r2, D3);
    release_out();

    // Randomized blocks against the reference.
    for (int i = 0; i < 8; i++) begin
      rd = 1'($urandom_range(0, 1));
      rk = {$urandom, $urandom, $urandom, $urandom};
      rx = {$urandom, $urandom};
      send(rd, rk, rx);
      wait_out(r, lat);
      chk($sformatf("rand_%0d", i), r, tea_model(rd, rk, rx, ROUNDS));
      release_out();
    end

    // Backpressure in DONE with a competing in_valid, then simultaneous
    // out_ready + in_valid: accept only happens one cycle later from IDLE.
    send(1'b0, 128'd0, 64'd0);
    wait_out(r, lat);
    in_valid = 1'b1; decrypt = 1'b0; key = K3; din = D3;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("bp_dout_%0d", i), dout, ZENC);
      chk($sformatf("bp_flags_%0d", i), {61'd0, in_ready, out_valid, busy}, 64'd3);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_idle_not_accepted", {61'd0, in_ready, out_valid, busy}, 64'd4);
    @(negedge clk);
    chk("bp_accept_next", {61'd0, in_ready, out_valid, busy}, 64'd1);
    in_valid = 1'b0;
    wait_out(r, lat);
    chk("bp_followup_dout", r, tea_model(1'b0, K3, D3, ROUNDS));
    release_out();

    // in_valid with other data during RUN is ignored.
    send(1'b0, 128'd0, 64'd0);
    repeat (5) @(negedge clk);
    in_valid = 1'b1; din = {$urandom, $urandom}; key = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("run_in_ready_%0d", i), {63'd0, in_ready}, 64'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    wait_out(r, lat);
    chk("run_ignore_dout", r, ZENC);
    release_out();

    // Reset mid-RUN: outputs clear before the next clock edge.
    send(1'b0, 128'd0, 64'd0);
    repeat (14) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_run_flags", {61'd0, in_ready, out_valid, busy}, 64'd4);
    chk("rst_run_dout", dout, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_run_no_partial", {61'd0, in_ready, out_valid, busy}, 64'd4);
    send(1'b0, 128'd0, 64'd0);
    wait_out(r, lat);
    chk("rst_fresh_dout", r, ZENC);
    chk("rst_fresh_latency", 64'(lat), 64'(ROUNDS));

    // Reset while held in DONE: out_valid drops asynchronously.
    #2 rst = 1'b1;
    #1;
    chk("rst_done_flags", {61'd0, in_ready, out_valid, busy}, 64'd4);
    chk("rst_done_dout", dout, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tea_round_engine.md
Name: tea_round_engine

Overview:
- Iterative TEA cipher core that drives two functionF instances and consumes their out32 results.
- Each clock performs one full TEA cycle, i.e. two Feistel half-rounds.
- Encrypts or decrypts one 64-bit block with a 128-bit key, using a valid/ready handshake on input and output.
- Sits between the block-level I/O wrapper and the functionF round function.

Parameters:
- ROUNDS, 32, number of TEA cycles per block; legal range 1..64.
- DELTA, 32'h9E3779B9, key-schedule constant.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- in_valid  input  1  din, key and decrypt are valid.
- in_ready  output  1  engine can accept a block.
- decrypt  input  1  0 = encrypt, 1 = decrypt; sampled on accept.
- key  input  128  k0=key[127:96], k1=key[95:64], k2=key[63:32], k3=key[31:0]; sampled on accept.
- din  input  64  v0=din[63:32], v1=din[31:0].
- out_valid  output  1  dout holds a finished block.
- out_ready  input  1  downstream accepts dout.
- dout  output  64  result, {v0,v1}.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (async, any state): state=IDLE, in_ready=1, out_valid=0, busy=0, dout=0, and the round counter, sum, v0, v1 and key registers all cleared.
- States:
  - IDLE: in_ready=1. When in_valid=1, latch key, decrypt, v0 and v1, load cnt=0, load sum, then go to RUN. Sum loads as DELTA for encrypt, DELTA*ROUNDS mod 2^32 for decrypt (0xC6EF3720 at ROUNDS=32).
  - RUN: in_ready=0. One cycle per round; cnt increments each cycle. When cnt==ROUNDS-1, write the final values and go to DONE.
  - DONE: out_valid=1 and dout={v0,v1}, both held stable. When out_ready=1, go to IDLE, out_valid=0 on the next edge.
- Encrypt round, using the current sum s:
  - v0' = v0 + F(k0,k1,s,v1)
  - v1' = v1 + F(k2,k3,s,v0')
  - s' = s + DELTA
- Decrypt round, using the current sum s:
  - v1' = v1 - F(k2,k3,s,v0)
  - v0' = v0 - F(k0,k1,s,v1')
  - s' = s - DELTA
- F(a,b,s,x) = ((x<<4)+a) ^ (x+s) ^ ((x>>5)+b). Shifts are logical. All additions and subtractions are mod 2^32 with carries discarded.
- The two functionF instances are chained combinationally within one cycle; the second instance consumes the first instance's result.
- Latency: accept edge, then ROUNDS RUN cycles, then out_valid. With zero backpressure, throughput is one block per ROUNDS+2 cycles.
- in_valid while busy=1 is ignored; in_ready=0 and nothing is latched.
- Changes on key or din after accept have no effect on the block in flight.
- DONE with out_ready=0: hold indefinitely; dout must not change.
- Simultaneous out_ready and a new in_valid in DONE: the new block is not accepted in that cycle; it is accepted on the following cycle from IDLE.
- Reset mid-RUN or mid-DONE: abort; out_valid drops asynchronously and no partial result is emitted.
- Counter width is 7 bits, so ROUNDS=64 does not wrap early.

Test Plan:
1. Encrypt, key=0, din=0, ROUNDS=32 -> out_valid at cycle 33 after accept; dout=64'h41EA3A0A_94BAA940.
2. Decrypt, key=0, din=64'h41EA3A0A_94BAA940 -> dout=0.
3. Random round-trip: key=128'h0123456789ABCDEF_FEDCBA9876543210, din=64'hDEADBEEF_CAFEBABE. Encrypt, then feed the result back with decrypt=1 -> original din. The encrypt output must match the C reference model.
4. Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and dout stable and in_ready=0 throughout; release -> IDLE next cycle.
5. Pulse in_valid with a different din during RUN -> ignored; result equals case 1.
6. Assert rst at RUN cycle 15 -> all outputs reset immediately. Then a fresh encrypt of case 1 -> same 64'h41EA3A0A_94BAA940.
